// File: rtl/dual_port_ram.sv
// Simple dual-port RAM (one write, one read port) with byte enables, an automatic clear after reset,
// and a selectable same-address collision rule. Define DPRAM_OUTREG_EN to add an output register (read latency 2).
module dual_port_ram #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int COLLISION_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DEPTH-1:0]     wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic                 rd_en,
    input  logic [DEPTH-1:0]     rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 init_busy
);
    localparam int NBYTES = WIDTH / 8;
    localparam int WORDS  = 2 ** DEPTH;
    localparam logic [DEPTH-1:0] LAST_ADDR = '1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_reg, state_next;
    logic [DEPTH-1:0]  clr_cnt_reg, clr_cnt_next;

    logic [WIDTH-1:0]  mem [WORDS];

    logic              mem_we;
    logic [DEPTH-1:0]  mem_addr;
    logic [WIDTH-1:0]  mem_din;
    logic [NBYTES-1:0] mem_be;

    logic              wr_fire;
    logic              rd_fire;
    logic [NBYTES-1:0] bypass;
    logic [WIDTH-1:0]  rd_word;

    logic [WIDTH-1:0]  rd_q_reg;
    logic              rd_q_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                clr_cnt_next = '0;
            end
            default: begin
                state_next   = CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    assign init_busy = rst || (state_reg == CLEAR);
    assign wr_fire   = wr_en && (state_reg == RUN);
    assign rd_fire   = rd_en && (state_reg == RUN);

    // The single write port is shared between the clear sweep and user writes.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = wr_addr;
        mem_din  = wr_data;
        mem_be   = wr_be;
        if (state_reg == CLEAR) begin
            mem_we   = !rst;
            mem_addr = clr_cnt_reg;
            mem_din  = '0;
            mem_be   = '1;
        end else begin
            mem_we   = wr_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
                end
            end
        end
    end

    // Write-first forwards the enabled bytes of a same-address write into the read result.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign bypass[gi] = (COLLISION_MODE == 1) && wr_fire && (wr_addr == rd_addr) && wr_be[gi];
            assign rd_word[8*gi +: 8] = bypass[gi] ? wr_data[8*gi +: 8] : mem[rd_addr][8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q_reg       <= '0;
            rd_q_valid_reg <= 1'b0;
        end else begin
            rd_q_valid_reg <= rd_fire;
            if (rd_fire) begin
                rd_q_reg <= rd_word;
            end
        end
    end

`ifdef DPRAM_OUTREG_EN
    logic [WIDTH-1:0] out_reg;
    logic             out_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= rd_q_valid_reg;
            if (rd_q_valid_reg) begin
                out_reg <= rd_q_reg;
            end
        end
    end

    assign rd_data  = out_reg;
    assign rd_valid = out_valid_reg;
`else
    assign rd_data  = rd_q_reg;
    assign rd_valid = rd_q_valid_reg;
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: expected read results are queued at issue time with a due cycle
// and checked by a monitor when rd_valid pulses; reset/clear behaviour is checked inline.
module tb_dual_port_ram;
    parameter int WIDTH          = 16;
    parameter int DEPTH          = 4;
    parameter int COLLISION_MODE = 0;

`ifdef DPRAM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int WORDS = 2 ** DEPTH;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en;
    logic [DEPTH-1:0]     wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [WIDTH/8-1:0]   wr_be;
    logic                 rd_en;
    logic [DEPTH-1:0]     rd_addr;
    logic [WIDTH-1:0]     rd_data;
    logic                 rd_valid;
    logic                 init_busy;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [WIDTH-1:0] exp_mem [WORDS];

    dual_port_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .COLLISION_MODE(COLLISION_MODE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_be(wr_be),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every rd_valid must match the oldest queued read, on its due cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL read_missing: no rd_valid by cycle %0d, required data %h", sb[0].due, sb[0].data);
            void'(sb.pop_front());
        end
        if (rd_valid) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_valid: rd_valid=1 data=%h at cycle %0d, required no read result", rd_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (rd_data !== mon_e.data || cyc !== mon_e.due) begin
                    tests_failed++;
                    $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d", rd_data, cyc, mon_e.data, mon_e.due);
                end else begin
                    $display("[TB] read ok data=%h cycle=%0d", rd_data, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = 1'b0;
        wr_be = '0;
        rd_en = 1'b0;
    endtask

    task automatic set_write(input int a, input logic [WIDTH-1:0] d, input logic [WIDTH/8-1:0] be);
        wr_en   = 1'b1;
        wr_addr = DEPTH'(a);
        wr_data = d;
        wr_be   = be;
        for (int b = 0; b < WIDTH / 8; b++) begin
            if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        $display("[TB] write addr=%0d data=%h be=%b", a, d, be);
    endtask

    task automatic set_read(input int a, input logic [WIDTH-1:0] expv);
        exp_t e;
        rd_en   = 1'b1;
        rd_addr = DEPTH'(a);
        e.data  = expv;
        e.due   = cyc + L;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d reads outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (init_busy && n < 40) begin
            tick();
            n++;
        end
        for (int a = 0; a < WORDS; a++) exp_mem[a] = '0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        clear_inputs();
        repeat (3) tick();
        tests_run += 3;
        if (init_busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: init_busy=%b, required 1", init_busy); end
        if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: rd_valid=%b, required 0", rd_valid); end
        if (rd_data !== '0) begin tests_failed++; $display("FAIL reset_data: rd_data=%h, required 0", rd_data); end
        // Requests during the clear must be ignored.
        wr_en = 1'b1; wr_addr = DEPTH'(2); wr_data = '1; wr_be = '1;
        rd_en = 1'b1; rd_addr = DEPTH'(2);
        rst = 1'b0;
        wait_clear(n);
        clear_inputs();
        tests_run++;
        if (n !== 16) begin tests_failed++; $display("FAIL clear_length: init_busy high %0d cycles, required 16", n); end
        $display("[TB] clear took %0d cycles", n);
    endtask

    task automatic test_clear_zero();
        for (int a = 0; a < WORDS; a++) begin
            set_read(a, '0);
            tick();
        end
        clear_inputs();
        drain("clear_zero");
    endtask

    task automatic test_write_read();
        set_write(15, 16'h00A5, 2'b11);
        tick();
        clear_inputs();
        set_read(15, 16'h00A5);
        tick();
        clear_inputs();
`ifdef DPRAM_OUTREG_EN
        tests_run++;
        if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_early: rd_valid=%b one cycle after rd_en, required 0", rd_valid); end
        tick();
`endif
        tests_run++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h00A5) begin
            tests_failed++;
            $display("FAIL latency: rd_valid=%b rd_data=%h after %0d cycles, required 1 and 00a5", rd_valid, rd_data, L);
        end
        drain("write_read");
    endtask

    task automatic test_byte_enable();
        set_write(7, 16'h1234, 2'b11); tick();
        set_write(7, 16'hABCD, 2'b01); tick();
        clear_inputs();
        set_read(7, 16'h12CD); tick(); clear_inputs();
        set_write(7, 16'hFFFF, 2'b00); tick(); clear_inputs();
        set_read(7, 16'h12CD); tick(); clear_inputs();
        set_write(7, 16'h5600, 2'b10); tick(); clear_inputs();
        set_read(7, 16'h56CD); tick(); clear_inputs();
        drain("byte_enable");
    endtask

    task automatic test_collision();
        set_write(3, 16'h0011, 2'b11); tick(); clear_inputs();
        set_read(3, (COLLISION_MODE == 1) ? 16'h0022 : 16'h0011);
        set_write(3, 16'h0022, 2'b11);
        tick(); clear_inputs();
        set_read(3, (COLLISION_MODE == 1) ? 16'h0044 : 16'h0022);
        set_write(3, 16'h3344, 2'b01);
        tick(); clear_inputs();
        set_write(4, 16'hBEEF, 2'b11);
        set_read(3, 16'h0044);
        tick(); clear_inputs();
        set_read(4, 16'hBEEF); tick(); clear_inputs();
        drain("collision");
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int a = 0; a < WORDS; a++) begin
            set_write(a, WIDTH'(a * 16'h1111) ^ 16'h5A3C, 2'b11);
            tick();
        end
        clear_inputs();
        for (int a = 0; a < WORDS; a++) begin
            set_read(a, exp_mem[a]);
            tick();
            if (rd_valid) pulses++;
        end
        clear_inputs();
        repeat (L - 1) begin
            tick();
            if (rd_valid) pulses++;
        end
        tests_run++;
        if (pulses !== 16) begin tests_failed++; $display("FAIL b2b_pulses: %0d rd_valid pulses, required 16", pulses); end
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        int n;
        int bad_valid = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (7) tick();
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (init_busy !== 1'b1 || rd_data !== '0 || rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_clear_rst: busy=%b data=%h valid=%b, required 1 0 0", init_busy, rd_data, rd_valid);
        end
        tick(); rst = 1'b0;
        wait_clear(n);
        tests_run++;
        if (n !== 16) begin tests_failed++; $display("FAIL restart_clear: %0d cycles, required 16", n); end
        set_write(9, 16'h7777, 2'b11); tick(); clear_inputs();
        set_read(9, 16'h7777); tick(); clear_inputs();
        drain("pre_rst_read");
        // Read issued and reset before it can complete: it must vanish.
        rd_en = 1'b1; rd_addr = DEPTH'(9);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (rd_data !== '0) begin tests_failed++; $display("FAIL rst_data: rd_data=%h, required 0", rd_data); end
        repeat (4) begin
            tick();
            if (rd_valid !== 1'b0) bad_valid++;
        end
        clear_inputs();
        tests_run++;
        if (bad_valid !== 0) begin tests_failed++; $display("FAIL rst_read_valid: %0d rd_valid pulses, required 0", bad_valid); end
        rst = 1'b0;
        wait_clear(n);
        tests_run++;
        if (n !== 16) begin tests_failed++; $display("FAIL rst_read_clear: %0d cycles, required 16", n); end
        set_read(9, '0); tick(); clear_inputs();
        drain("post_clear");
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        for (int a = 0; a < WORDS; a++) exp_mem[a] = '0;
        test_reset();
        test_clear_zero();
        test_write_read();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
